fma16_arb_seq: RTL and testbench
================================

Name: fma16_arb_seq

Overview:
- Shares one multi-cycle fp16 FMA datapath (multiply, align/add, normalize, round) between two requesters.
- Round-robin arbitration between the requesters; sequences the datapath stage enables through a state machine.
- Captures the datapath result at the end of rounding and holds it on a response port until the winning requester accepts it.
- Sits between the core-side request ports and the fma16 datapath.

Parameters:
- STAGE_CYC, 1, cycles each datapath stage enable stays asserted (1..7).
- FAST_SPECIAL, 1, when 1, operands with any exponent field 5'h1F skip the ADD and NORM states.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  2  request valid, one bit per requester.
- req_ready  out  2  request accepted this cycle (at most one bit high).
- req_x  in  32  X operands, {r1,r0} 16 bits each.
- req_y  in  32  Y operands.
- req_z  in  32  Z operands.
- req_op  in  4  {negp,negz} per requester.
- req_rm  in  4  rounding mode per requester.
- dp_x, dp_y, dp_z  out  16 each  registered operands driven to the datapath.
- dp_op  out  2  registered op.
- dp_rm  out  2  registered rounding mode.
- dp_mul_en, dp_add_en, dp_norm_en, dp_rnd_en  out  1 each  stage enables.
- dp_result  in  16  datapath result, valid during the final RND cycle.
- dp_flags  in  4  {NV,OF,UF,NX}, valid during the final RND cycle.
- rsp_valid  out  2  response valid, one-hot to the owning requester.
- rsp_ready  in  2  response accept.
- rsp_result  out  16  held result.
- rsp_flags  out  4  held flags.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, all outputs 0, counter 0.
  - Priority pointer last=1, so requester 0 wins the first tie.
  - A reset during any state drops the in-flight op: no response is issued and no flags are retained.
- States: IDLE, MUL, ADD, NORM, RND, RESP.
- IDLE:
  - req_ready is combinational, asserted only in IDLE. Grant goes to the single valid requester; if both are valid, to requester !last.
  - On the grant edge: register operands/op/rm into dp_*, record owner, set last=owner, state->MUL, counter=0.
- Stage states:
  - The matching dp_*_en is high for exactly STAGE_CYC cycles; the counter advances each cycle and clears on each transition.
  - Transitions: MUL->ADD->NORM->RND.
  - MUL exit: if FAST_SPECIAL=1 and any of dp_x/dp_y/dp_z has exponent [14:10]==5'h1F, MUL->RND directly.
  - Only one enable is high at a time.
- RND: on its final cycle, latch dp_result/dp_flags into rsp_result/rsp_flags; state->RESP.
- RESP:
  - rsp_valid[owner]=1, result held stable.
  - Exits to IDLE on the cycle after rsp_ready[owner]=1 seen with rsp_valid. rsp_ready of the non-owner is ignored.
  - rsp_valid drops in IDLE; rsp_result/rsp_flags keep their values until the next latch.
- Latency, request accept edge to rsp_valid high:
  - Normal path: 4*STAGE_CYC cycles (4 at default).
  - Fast path: 2*STAGE_CYC cycles.
- Throughput: one op in flight. Earliest next grant is the cycle after the response handshake. A requester whose valid is high during RESP waits.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1.
- Protocol: req_valid/operands must stay stable until req_ready. A drop before grant is legal; that requester is simply not granted.
- dp_* operand registers hold their value in IDLE (no toggling between ops).

Decomposition:
- fma16_pkg: state enum fsm_t; localparams EXP_ALL1=5'h1F and NREQ=2; flags struct {nv,of,uf,nx}.
- Sub-module rr_arb2: 2-way round-robin arbiter (req, last -> one-hot grant), reusable elsewhere.
- The FSM, counter and capture registers stay in the top module.

Test Plan:
- Req0 only: X=0x3C00, Y=0x3C00, Z=0x3C00, rm=RNE, with datapath model -> req_ready[0] one cycle; stage enables in order for 1 cycle each; rsp_valid=2'b01 after 4 cycles; rsp_result=0x4000, flags=0.
- Both valid from reset with distinct ops, rsp_ready tied high -> grants 0 then 1 then 0. Each response goes to the correct one-hot rsp_valid bit, and a new grant comes 1 cycle after each response handshake.
- X=0x7C00 (inf), Y=0x3C00, Z=0xFC00 -> fast path: dp_add_en and dp_norm_en never assert; rsp_valid after 2 cycles; result 0x7E00 with NV=1 from the model.
- STAGE_CYC=3, normal op -> each enable high for 3 cycles; rsp_valid after 12 cycles; rsp_ready held low 5 cycles -> result stable, no grant to the other valid requester until the handshake.
- Assert reset_n=0 during ADD -> outputs 0 immediately; no rsp_valid after release; last=1, so requester 0 wins the next tie.
- rsp_ready[1]=1 while owner=0 -> ignored, RESP persists; rsp_ready[0]=1 -> IDLE next cycle.

Source files
------------

// File: rtl/fma16_arb_seq_pkg.sv
// Shared types and constants for the two-requester fp16 FMA sequencer.
package fma16_pkg;

  localparam logic [4:0] EXP_ALL1 = 5'h1F;
  localparam int         NREQ     = 2;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    ADD,
    NORM,
    RND,
    RESP
  } fsm_t;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } flags_t;

  // Inf/NaN operand: exponent field all ones.
  function automatic logic is_special(input logic [15:0] v);
    return v[14:10] == EXP_ALL1;
  endfunction

endpackage

// File: rtl/fma16_arb_seq_if.sv
// Core-side request/response bundle: the core is the master, the sequencer the slave.
interface fma16_arb_seq_if;
  import fma16_pkg::*;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*16-1:0] req_x;
  logic [NREQ*16-1:0] req_y;
  logic [NREQ*16-1:0] req_z;
  logic [NREQ*2-1:0]  req_op;
  logic [NREQ*2-1:0]  req_rm;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [15:0]        rsp_result;
  logic [3:0]         rsp_flags;

  modport master (
    output req_valid, req_x, req_y, req_z, req_op, req_rm, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_x, req_y, req_z, req_op, req_rm, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags
  );

endinterface

// File: rtl/fma16_arb_seq_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the one not served last.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/fma16_arb_seq.sv
// Arbitrates two requesters onto one multi-cycle fp16 FMA datapath, steps its stage
// enables, and holds the rounded result on the response port until the owner accepts.
module fma16_arb_seq
  import fma16_pkg::*;
#(
  parameter int STAGE_CYC    = 1,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fma16_arb_seq_if.slave        core,
  output logic [15:0]           dp_x,
  output logic [15:0]           dp_y,
  output logic [15:0]           dp_z,
  output logic [1:0]            dp_op,
  output logic [1:0]            dp_rm,
  output logic                  dp_mul_en,
  output logic                  dp_add_en,
  output logic                  dp_norm_en,
  output logic                  dp_rnd_en,
  input  logic [15:0]           dp_result,
  input  logic [3:0]            dp_flags,
  output logic                  busy
);

  localparam int               CNT_W    = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_CYC - 1);

  fsm_t             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q;
  logic             owner_q;
  logic [15:0]      x_q, y_q, z_q;
  logic [1:0]       op_q, rm_q;
  logic [15:0]      result_q;
  flags_t           flags_q;

  logic [NREQ-1:0]  gnt;
  logic             gnt_idx;
  logic             grab;
  logic             latch;
  logic             stage_done;
  logic             special;

  rr_arb2 u_arb (
    .req_i  (core.req_valid),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign gnt_idx    = gnt[1];
  assign stage_done = (cnt_q == CNT_LAST);
  assign special    = FAST_SPECIAL &&
                      (is_special(x_q) || is_special(y_q) || is_special(z_q));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + 1'b1;
    grab           = 1'b0;
    latch          = 1'b0;
    dp_mul_en      = 1'b0;
    dp_add_en      = 1'b0;
    dp_norm_en     = 1'b0;
    dp_rnd_en      = 1'b0;
    core.req_ready = '0;
    core.rsp_valid = '0;
    case (state_q)
      IDLE: begin
        cnt_d          = '0;
        core.req_ready = gnt;
        if (|gnt) begin
          grab    = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        dp_mul_en = 1'b1;
        if (stage_done) state_d = special ? RND : ADD;
      end
      ADD: begin
        dp_add_en = 1'b1;
        if (stage_done) state_d = NORM;
      end
      NORM: begin
        dp_norm_en = 1'b1;
        if (stage_done) state_d = RND;
      end
      RND: begin
        dp_rnd_en = 1'b1;
        if (stage_done) begin
          latch   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d                   = '0;
        core.rsp_valid[owner_q] = 1'b1;
        // Only the owner's accept counts; the other requester's rsp_ready is ignored.
        if (core.rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      op_q     <= '0;
      rm_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grab) begin
        owner_q <= gnt_idx;
        last_q  <= gnt_idx;
        x_q     <= gnt_idx ? core.req_x[31:16] : core.req_x[15:0];
        y_q     <= gnt_idx ? core.req_y[31:16] : core.req_y[15:0];
        z_q     <= gnt_idx ? core.req_z[31:16] : core.req_z[15:0];
        op_q    <= gnt_idx ? core.req_op[3:2]  : core.req_op[1:0];
        rm_q    <= gnt_idx ? core.req_rm[3:2]  : core.req_rm[1:0];
      end
      if (latch) begin
        result_q <= dp_result;
        flags_q  <= dp_flags;
      end
    end
  end

  assign dp_x            = x_q;
  assign dp_y            = y_q;
  assign dp_z            = z_q;
  assign dp_op           = op_q;
  assign dp_rm           = rm_q;
  assign core.rsp_result = result_q;
  assign core.rsp_flags  = flags_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_fma16_arb_seq.sv
// Bench for fma16_arb_seq: two instances (STAGE_CYC 1 and 3) against a transaction-level
// model of grant order, stage timing, response ownership and held results.
module tb_fma16_arb_seq;
  import fma16_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus and observed signals, one entry per DUT instance.
  logic [1:0]  req_valid  [2];
  logic [31:0] req_x      [2];
  logic [31:0] req_y      [2];
  logic [31:0] req_z      [2];
  logic [3:0]  req_op     [2];
  logic [3:0]  req_rm     [2];
  logic [1:0]  rsp_ready  [2];
  logic [1:0]  req_ready  [2];
  logic [1:0]  rsp_valid  [2];
  logic [15:0] rsp_result [2];
  logic [3:0]  rsp_flags  [2];
  logic [15:0] dp_x       [2];
  logic [15:0] dp_y       [2];
  logic [15:0] dp_z       [2];
  logic [1:0]  dp_op      [2];
  logic [1:0]  dp_rm      [2];
  logic [15:0] dp_result  [2];
  logic [3:0]  dp_flags   [2];
  logic [3:0]  en         [2];   // {mul, add, norm, rnd}
  logic        busy_o     [2];

  // Reference model state.
  bit          busy_m   [2];
  int          t_m      [2];
  bit          last_m   [2];
  bit          owner_m  [2];
  bit          fast_m   [2];
  logic [15:0] ex_x     [2];
  logic [15:0] ex_y     [2];
  logic [15:0] ex_z     [2];
  logic [1:0]  ex_op    [2];
  logic [1:0]  ex_rm    [2];
  logic [15:0] ex_res   [2];
  logic [3:0]  ex_flg   [2];
  logic [15:0] pend_res [2];
  logic [3:0]  pend_flg [2];
  logic [1:0]  gnt_seen [2];
  int          n_rsp    [2];
  int          glog0 [$];
  bit          rand_en = 1'b0;

  function automatic int sc_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Datapath stand-in: 1*1+1 = 2, any Inf/NaN operand gives the default NaN with NV,
  // everything else an operand-dependent signature.
  function automatic logic [19:0] dp_stub(input logic [15:0] x, input logic [15:0] y,
                                          input logic [15:0] z, input logic [1:0] op,
                                          input logic [1:0] rm);
    logic [15:0] r;
    if (x[14:10] == 5'h1F || y[14:10] == 5'h1F || z[14:10] == 5'h1F)
      return {4'b1000, 16'h7E00};
    if (x == 16'h3C00 && y == 16'h3C00 && z == 16'h3C00 && op == 2'b00)
      return {4'b0000, 16'h4000};
    r = x ^ {y[7:0], y[15:8]} ^ (z + {14'b0, op}) ^ {rm, 14'b0};
    return {1'b0, r[2:0] ^ x[2:0], r};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int SCG = (g == 0) ? 1 : 3;
    fma16_arb_seq_if bus ();
    logic        mul_en, add_en, norm_en, rnd_en;
    logic [2:0]  rnd_seen;
    logic [19:0] stub;
    logic        final_rnd;

    assign bus.req_valid = req_valid[g];
    assign bus.req_x     = req_x[g];
    assign bus.req_y     = req_y[g];
    assign bus.req_z     = req_z[g];
    assign bus.req_op    = req_op[g];
    assign bus.req_rm    = req_rm[g];
    assign bus.rsp_ready = rsp_ready[g];
    assign req_ready[g]  = bus.req_ready;
    assign rsp_valid[g]  = bus.rsp_valid;
    assign rsp_result[g] = bus.rsp_result;
    assign rsp_flags[g]  = bus.rsp_flags;
    assign en[g]         = {mul_en, add_en, norm_en, rnd_en};

    // The result is only meaningful on the last RND cycle; garbage otherwise.
    always @(posedge clk or negedge reset_n)
      if (!reset_n) rnd_seen <= 3'd0;
      else          rnd_seen <= rnd_en ? rnd_seen + 3'd1 : 3'd0;

    assign stub         = dp_stub(dp_x[g], dp_y[g], dp_z[g], dp_op[g], dp_rm[g]);
    assign final_rnd    = rnd_en && (rnd_seen == 3'(SCG - 1));
    assign dp_result[g] = final_rnd ? stub[15:0]  : 16'hBAD0;
    assign dp_flags[g]  = final_rnd ? stub[19:16] : 4'hF;

    fma16_arb_seq #(.STAGE_CYC(SCG), .FAST_SPECIAL(1'b1)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .core       (bus),
      .dp_x       (dp_x[g]),
      .dp_y       (dp_y[g]),
      .dp_z       (dp_z[g]),
      .dp_op      (dp_op[g]),
      .dp_rm      (dp_rm[g]),
      .dp_mul_en  (mul_en),
      .dp_add_en  (add_en),
      .dp_norm_en (norm_en),
      .dp_rnd_en  (rnd_en),
      .dp_result  (dp_result[g]),
      .dp_flags   (dp_flags[g]),
      .busy       (busy_o[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Per-cycle model step for instance k, sampled on the falling edge.
  task automatic mon(input int k);
    int         sc, lat;
    logic [3:0] xen;
    logic [1:0] xrv, xrdy, v;
    logic       xbusy;
    bit         ow;
    sc = sc_of(k);
    if (!reset_n) begin
      busy_m[k] = 0; last_m[k] = 1; owner_m[k] = 0; fast_m[k] = 0; t_m[k] = 0;
      ex_x[k] = '0; ex_y[k] = '0; ex_z[k] = '0; ex_op[k] = '0; ex_rm[k] = '0;
      ex_res[k] = '0; ex_flg[k] = '0; gnt_seen[k] = '0;
      check($sformatf("k%0d_rst_busy", k), 32'(busy_o[k]), 32'd0);
      check($sformatf("k%0d_rst_en", k), 32'(en[k]), 32'd0);
      check($sformatf("k%0d_rst_rsp_valid", k), 32'(rsp_valid[k]), 32'd0);
      return;
    end
    gnt_seen[k] = 2'b00;
    xen = '0; xrv = '0; xrdy = '0; xbusy = 1'b0;
    lat = fast_m[k] ? 2 * sc : 4 * sc;
    if (busy_m[k]) begin
      t_m[k]++;
      xbusy = 1'b1;
      if (t_m[k] < sc)                       xen = 4'b1000;
      else if (!fast_m[k] && t_m[k] < 2 * sc) xen = 4'b0100;
      else if (!fast_m[k] && t_m[k] < 3 * sc) xen = 4'b0010;
      else if (t_m[k] < lat)                 xen = 4'b0001;
      if (t_m[k] == lat) begin
        ex_res[k] = pend_res[k];
        ex_flg[k] = pend_flg[k];
      end
      if (t_m[k] >= lat) xrv = owner_m[k] ? 2'b10 : 2'b01;
    end else begin
      v = req_valid[k];
      if (v == 2'b01 || v == 2'b10) xrdy = v;
      else if (v == 2'b11)          xrdy = last_m[k] ? 2'b01 : 2'b10;
    end
    check($sformatf("k%0d_req_ready", k), 32'(req_ready[k]), 32'(xrdy));
    check($sformatf("k%0d_busy", k), 32'(busy_o[k]), 32'(xbusy));
    check($sformatf("k%0d_stage_en", k), 32'(en[k]), 32'(xen));
    check($sformatf("k%0d_rsp_valid", k), 32'(rsp_valid[k]), 32'(xrv));
    check($sformatf("k%0d_rsp_result", k), 32'(rsp_result[k]), 32'(ex_res[k]));
    check($sformatf("k%0d_rsp_flags", k), 32'(rsp_flags[k]), 32'(ex_flg[k]));
    check($sformatf("k%0d_dp_xyz", k), {dp_x[k], dp_y[k] ^ dp_z[k]},
          {ex_x[k], ex_y[k] ^ ex_z[k]});
    check($sformatf("k%0d_dp_oprm", k), {dp_op[k], dp_rm[k], dp_z[k]},
          {ex_op[k], ex_rm[k], ex_z[k]});
    if (busy_m[k]) begin
      if (xrv != 2'b00 && (rsp_ready[k] & xrv) != 2'b00) begin
        busy_m[k] = 0;
        n_rsp[k]++;
      end
    end else if (xrdy != 2'b00) begin
      ow          = xrdy[1];
      gnt_seen[k] = xrdy;
      owner_m[k]  = ow;
      last_m[k]   = ow;
      ex_x[k]     = req_x[k][ow*16 +: 16];
      ex_y[k]     = req_y[k][ow*16 +: 16];
      ex_z[k]     = req_z[k][ow*16 +: 16];
      ex_op[k]    = req_op[k][ow*2 +: 2];
      ex_rm[k]    = req_rm[k][ow*2 +: 2];
      fast_m[k]   = (ex_x[k][14:10] == 5'h1F) || (ex_y[k][14:10] == 5'h1F) ||
                    (ex_z[k][14:10] == 5'h1F);
      {pend_flg[k], pend_res[k]} = dp_stub(ex_x[k], ex_y[k], ex_z[k], ex_op[k], ex_rm[k]);
      busy_m[k]   = 1;
      t_m[k]      = -1;
      if (k == 0) glog0.push_back(int'(ow));
    end
  endtask

  task automatic set_req(input int k, input int r, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] z, input logic [1:0] op, input logic [1:0] rm);
    req_x[k][r*16 +: 16] = x;
    req_y[k][r*16 +: 16] = y;
    req_z[k][r*16 +: 16] = z;
    req_op[k][r*2 +: 2]  = op;
    req_rm[k][r*2 +: 2]  = rm;
    req_valid[k][r]      = 1'b1;
  endtask

  task automatic new_req(input int k, input int r);
    logic [15:0] a, b, c;
    a = 16'($urandom);
    b = 16'($urandom);
    c = 16'($urandom);
    if ($urandom_range(7) == 0) a[14:10] = 5'h1F;
    if ($urandom_range(7) == 0) b[14:10] = 5'h1F;
    if ($urandom_range(7) == 0) c[14:10] = 5'h1F;
    set_req(k, r, a, b, c, 2'($urandom), 2'($urandom));
  endtask

  // One clock: model step on the falling edge, input update just after the rising edge.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) mon(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 2; r++)
        if (gnt_seen[k][r]) req_valid[k][r] = 1'b0;
      if (rand_en) begin
        for (int r = 0; r < 2; r++) begin
          if (!req_valid[k][r]) begin
            if ($urandom_range(2) == 0) new_req(k, r);
          end else if ($urandom_range(15) == 0) begin
            req_valid[k][r] = 1'b0;
          end
        end
        rsp_ready[k] = 2'($urandom);
      end
    end
  endtask

  task automatic wait_rsp(input int k, output int n, output bit saw_mid);
    n       = 0;
    saw_mid = 1'b0;
    while (rsp_valid[k] == 2'b00 && n < 100) begin
      tick();
      n++;
      saw_mid = saw_mid | en[k][2] | en[k][1];
    end
    check($sformatf("k%0d_rsp_seen", k), 32'(rsp_valid[k] != 2'b00), 32'd1);
  endtask

  initial begin
    int          n;
    bit          saw_mid;
    logic [19:0] exp_d;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = '0; req_x[k] = '0; req_y[k] = '0; req_z[k] = '0;
      req_op[k] = '0; req_rm[k] = '0; rsp_ready[k] = '0; n_rsp[k] = 0;
    end
    tick();
    tick();
    reset_n = 1'b1;

    // Requester 0 alone: 1*1+1, normal path.
    set_req(0, 0, 16'h3C00, 16'h3C00, 16'h3C00, 2'b00, 2'b00);
    wait_rsp(0, n, saw_mid);
    check("a_latency", 32'(n - 1), 32'd4);
    check("a_rsp_valid", 32'(rsp_valid[0]), 32'h1);
    check("a_result", 32'(rsp_result[0]), 32'h4000);
    check("a_flags", 32'(rsp_flags[0]), 32'h0);
    rsp_ready[0] = 2'b10;
    repeat (3) tick();
    check("a_nonowner_ignored", {31'd0, busy_o[0]}, 32'd1);
    check("a_nonowner_rsp_valid", 32'(rsp_valid[0]), 32'h1);
    rsp_ready[0] = 2'b01;
    tick();
    check("a_idle_after_hs", {31'd0, busy_o[0]}, 32'd0);
    check("a_result_held", 32'(rsp_result[0]), 32'h4000);
    rsp_ready[0] = 2'b00;
    tick();

    // Requester 1 alone, Inf*1 + -Inf: fast path.
    set_req(0, 1, 16'h7C00, 16'h3C00, 16'hFC00, 2'b00, 2'b00);
    wait_rsp(0, n, saw_mid);
    check("b_latency", 32'(n - 1), 32'd2);
    check("b_no_add_norm", {31'd0, saw_mid}, 32'd0);
    check("b_rsp_valid", 32'(rsp_valid[0]), 32'h2);
    check("b_result", 32'(rsp_result[0]), 32'h7E00);
    check("b_flags", 32'(rsp_flags[0]), 32'h8);
    rsp_ready[0] = 2'b11;
    tick();
    rsp_ready[0] = 2'b00;

    // Fresh reset, both continuously valid, responses always accepted.
    reset_n = 1'b0;
    req_valid[0] = '0;
    tick();
    tick();
    reset_n = 1'b1;
    glog0.delete();
    rsp_ready[0] = 2'b11;
    set_req(0, 0, 16'h4000, 16'h4200, 16'h3800, 2'b01, 2'b00);
    set_req(0, 1, 16'h4400, 16'h3C00, 16'hBC00, 2'b10, 2'b01);
    repeat (30) begin
      tick();
      for (int r = 0; r < 2; r++)
        if (!req_valid[0][r]) set_req(0, r, 16'(16'h4000 + $urandom_range(1023)),
                                      16'h3C00, 16'h3800, 2'($urandom), 2'b00);
    end
    check("c_grant_count", 32'(glog0.size() >= 4), 32'd1);
    if (glog0.size() >= 4) begin
      check("c_grant0", 32'(glog0[0]), 32'd0);
      check("c_grant1", 32'(glog0[1]), 32'd1);
      check("c_grant2", 32'(glog0[2]), 32'd0);
      check("c_grant3", 32'(glog0[3]), 32'd1);
    end
    req_valid[0] = '0;
    repeat (20) tick();
    rsp_ready[0] = 2'b00;

    // STAGE_CYC=3 instance: slow accept while the other requester waits.
    set_req(1, 0, 16'h4000, 16'h3C00, 16'h3800, 2'b00, 2'b00);
    exp_d = dp_stub(16'h4000, 16'h3C00, 16'h3800, 2'b00, 2'b00);
    wait_rsp(1, n, saw_mid);
    check("d_latency", 32'(n - 1), 32'd12);
    set_req(1, 1, 16'h3E00, 16'h4100, 16'h3400, 2'b11, 2'b10);
    repeat (5) begin
      tick();
      check("d_result_stable", 32'(rsp_result[1]), 32'(exp_d[15:0]));
      check("d_no_grant", 32'(req_ready[1]), 32'd0);
    end
    rsp_ready[1] = 2'b01;
    tick();
    rsp_ready[1] = 2'b10;
    wait_rsp(1, n, saw_mid);
    check("d_second_owner", 32'(rsp_valid[1]), 32'h2);
    tick();
    rsp_ready[1] = 2'b00;

    // Reset while the op is in ADD.
    set_req(0, 0, 16'h4400, 16'h3C00, 16'h3C00, 2'b00, 2'b01);
    n = 0;
    while (!en[0][2] && n < 20) begin
      tick();
      n++;
    end
    check("e_add_seen", {31'd0, en[0][2]}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("e_rst_busy", {31'd0, busy_o[0]}, 32'd0);
    check("e_rst_en", 32'(en[0]), 32'd0);
    check("e_rst_dp_x", 32'(dp_x[0]), 32'd0);
    check("e_rst_result", {12'd0, rsp_flags[0], rsp_result[0]}, 32'd0);
    req_valid[0] = '0;
    req_valid[1] = '0;
    tick();
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
    check("e_no_rsp", 32'(rsp_valid[0]), 32'd0);
    set_req(0, 0, 16'h3C00, 16'h4000, 16'h3C00, 2'b00, 2'b00);
    set_req(0, 1, 16'h4000, 16'h4000, 16'h3C00, 2'b01, 2'b00);
    #1;
    check("e_tie_ready", 32'(req_ready[0]), 32'h1);
    tick();
    check("e_tie_grant", 32'(glog0[glog0.size() - 1]), 32'd0);
    rsp_ready[0] = 2'b11;
    repeat (20) tick();

    // Randomised traffic on both instances.
    rand_en = 1'b1;
    repeat (3000) tick();
    rand_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = '0;
      rsp_ready[k] = 2'b11;
    end
    repeat (40) tick();
    check("f_drained0", {31'd0, busy_o[0]}, 32'd0);
    check("f_drained1", {31'd0, busy_o[1]}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
